// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor processing CHUNK bits per clock, LSB chunk first.
module serial_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CHUNK:0]   part;
    logic             last, load;

    assign part = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
    assign last = cnt_q == CW'(N - 1);
    assign load = start && (state_q != RUN);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (load) begin
            state_d = RUN;
            a_d     = a;
            b_d     = sub ? ~b : b;
            carry_d = sub | cin;
            cnt_d   = '0;
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end else if (state_q == RUN) begin
            a_d     = a_q >> CHUNK;
            b_d     = b_q >> CHUNK;
            res_d   = (res_q >> CHUNK) | (WIDTH'(part[CHUNK-1:0]) << (WIDTH - CHUNK));
            carry_d = part[CHUNK];
            cnt_d   = cnt_q + CW'(1);
            if (last) begin
                state_d = DONE;
                sum_d   = res_d;
                cout_d  = part[CHUNK];
                // carry into the MSB is recovered from that bit's own a^b^sum
                ovf_d   = a_q[CHUNK-1] ^ b_q[CHUNK-1] ^ part[CHUNK-1] ^ part[CHUNK];
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = state_q == RUN;
    assign done = state_q == DONE;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench over five serial_adder instances with CHUNK = 1,2,4,8,16.
module tb_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, cin, sub;
    logic [15:0] a, b;
    logic [4:0]  start_v, busy_w, done_w, cout_w, ovf_w;
    logic [15:0] sum_w [5];
    logic [15:0] last_sum [5];

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    exp_t q[$];
    int n_checks = 0;
    int n_pass   = 0;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        serial_adder #(.WIDTH(16), .CHUNK(1 << g)) u_dut (
            .clk(clk), .reset(reset), .start(start_v[g]), .a(a), .b(b), .cin(cin), .sub(sub),
            .busy(busy_w[g]), .done(done_w[g]), .sum(sum_w[g]), .cout(cout_w[g]), .ovf(ovf_w[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // independent reference: 17-bit add, overflow from operand/result sign rule
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic sb);
        logic [15:0] yy;
        logic [16:0] r;
        exp_t        e;
        yy  = sb ? ~y : y;
        r   = {1'b0, x} + {1'b0, yy} + {16'b0, sb | ci};
        e.s = r[15:0];
        e.c = r[16];
        e.o = (x[15] == yy[15]) && (r[15] != x[15]);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 5; k++) begin
                if (done_w[k]) begin
                    if (q.size() == 0) begin
                        check("spurious_done", 1, 0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        check("sum", sum_w[k], e.s);
                        check("cout", cout_w[k], e.c);
                        check("ovf", ovf_w[k], e.o);
                    end
                end
            end
        end
    end

    task automatic run_op(input int s, input logic [15:0] x, input logic [15:0] y,
                          input logic ci, input logic sb, input exp_t e);
        int   lat, bc;
        logic held;
        @(negedge clk);
        a = x; b = y; cin = ci; sub = sb; start_v[s] = 1'b1;
        q.push_back(e);
        @(negedge clk);
        start_v[s] = 1'b0;
        lat = 0; bc = 0; held = 1'b1;
        while (!done_w[s] && lat < 40) begin
            if (busy_w[s]) begin
                bc++;
                if (sum_w[s] != last_sum[s]) held = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 16 >> s);
        check("busy_cycles", bc, 16 >> s);
        check("hold_during_run", held, 1);
        last_sum[s] = e.s;
    endtask

    initial begin
        int          cnt, dc, lat;
        logic [15:0] x, y, corners [6];
        logic        ci, sb;
        corners = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'hFFFE};
        reset = 1'b1; start_v = '0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        for (int k = 0; k < 5; k++) last_sum[k] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("reset_busy", busy_w[k], 0);
            check("reset_done", done_w[k], 0);
            check("reset_sum", sum_w[k], 0);
            check("reset_cout", cout_w[k], 0);
            check("reset_ovf", ovf_w[k], 0);
        end

        run_op(0, 16'h1234, 16'h0001, 1'b0, 1'b0, '{16'h1235, 1'b0, 1'b0});
        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0});
        run_op(0, 16'h7FFF, 16'h0000, 1'b1, 1'b0, '{16'h8000, 1'b0, 1'b1});
        run_op(2, 16'h0005, 16'h0007, 1'b0, 1'b1, '{16'hFFFE, 1'b0, 1'b0});
        run_op(2, 16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1});

        // start pulsed mid-RUN with other operands must be ignored
        @(negedge clk);
        a = 16'h00F0; b = 16'h000F; cin = 1'b0; sub = 1'b0; start_v[0] = 1'b1;
        q.push_back('{16'h00FF, 1'b0, 1'b0});
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b1; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        lat = 0;
        while (!done_w[0] && lat < 40) begin @(negedge clk); lat++; end
        check("ignored_start_latency", lat, 12);
        dc = 0;
        repeat (30) begin @(negedge clk); dc += int'(done_w[0]); end
        check("ignored_start_no_extra_done", dc, 0);
        last_sum[0] = 16'h00FF;

        // back-to-back on CHUNK=4: start held through DONE
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start_v[2] = 1'b1;
        q.push_back('{16'h3333, 1'b0, 1'b0});
        @(negedge clk);
        lat = 0;
        while (!done_w[2] && lat < 40) begin @(negedge clk); lat++; end
        check("b2b_first_latency", lat, 4);
        a = 16'h0010; b = 16'h0020; sub = 1'b1;
        q.push_back('{16'hFFF0, 1'b0, 1'b0});
        cnt = 0;
        do begin
            @(negedge clk);
            start_v[2] = 1'b0;
            cnt++;
        end while (!done_w[2] && cnt < 40);
        check("b2b_spacing", cnt, 5);
        last_sum[2] = 16'hFFF0;

        // reset in the 5th RUN cycle aborts the operation
        run_op(0, 16'hC000, 16'h8000, 1'b0, 1'b0, '{16'h4000, 1'b1, 1'b1});
        @(negedge clk);
        a = 16'h1111; b = 16'h0001; cin = 1'b0; sub = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_abort", busy_w[0], 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", busy_w[0], 0);
        check("abort_done", done_w[0], 0);
        check("abort_sum", sum_w[0], 0);
        check("abort_cout", cout_w[0], 0);
        check("abort_ovf", ovf_w[0], 0);
        dc = 0;
        repeat (30) begin @(negedge clk); dc += int'(done_w[0]); end
        check("abort_no_done", dc, 0);
        for (int k = 0; k < 5; k++) last_sum[k] = '0;

        for (int s = 0; s < 5; s++) begin
            repeat (1000) begin
                x  = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
                y  = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 5)] : 16'($urandom);
                ci = 1'($urandom);
                sb = 1'($urandom);
                run_op(s, x, y, ci, sb, model(x, y, ci, sb));
            end
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
